ofdm_symbol_serializer: RTL and testbench

//  Downstream of the 16-point OFDM FFT stage. Captures one parallel frequency-to-time symbol
//  (N complex words) on the FFT completion pulse, prepends a cyclic prefix, and streams
//  the symbol out one complex sample per beat over a valid/ready interface toward the DAC/UART path.

---
 rtl/ofdm_symbol_serializer.sv | 187 ++++++++++++++++++
 tb/tb_ofdm_symbol_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_serializer.sv
// Captures a full parallel OFDM symbol, prepends a cyclic prefix and streams it out
// one complex sample per valid/ready beat, with a one-deep pending symbol buffer.
module ofdm_symbol_serializer #(
  parameter int WORD_SIZE = 16,
  parameter int N_POINTS  = 16,
  parameter int CP_LEN    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_sym_valid,
  input  logic [N_POINTS*WORD_SIZE-1:0] i_sym_re,
  input  logic [N_POINTS*WORD_SIZE-1:0] i_sym_im,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [WORD_SIZE-1:0]          o_re,
  output logic [WORD_SIZE-1:0]          o_im,
  output logic                          o_sop,
  output logic                          o_eop,
  output logic                          o_busy,
  output logic                          o_overflow
);

  localparam int IDX_W = $clog2(N_POINTS) + 1;
  localparam int SYM_W = N_POINTS * WORD_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_POINTS - 1);
  localparam logic [IDX_W-1:0] START_IDX = (CP_LEN > 0) ? IDX_W'(N_POINTS - CP_LEN) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_BODY
  } state_t;

  localparam state_t START_STATE = (CP_LEN > 0) ? ST_CP : ST_BODY;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SYM_W-1:0]     act_re_q, act_re_d;
  logic [SYM_W-1:0]     act_im_q, act_im_d;
  logic [SYM_W-1:0]     pend_re_q, pend_re_d;
  logic [SYM_W-1:0]     pend_im_q, pend_im_d;
  logic                 pend_full_q, pend_full_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] re_q, re_d;
  logic [WORD_SIZE-1:0] im_q, im_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;

  logic fire;
  logic take_input;
  logic take_pend;
  logic load;
  logic stash;
  logic drop;

  logic [WORD_SIZE-1:0] nxt_re_w [N_POINTS];
  logic [WORD_SIZE-1:0] nxt_im_w [N_POINTS];

  // A new symbol starts either from idle or on the eop transfer; pending has priority.
  assign fire       = valid_q && i_ready;
  assign take_pend  = fire && eop_q && pend_full_q;
  assign take_input = i_sym_valid &&
                      ((state_q == ST_IDLE) || (fire && eop_q && !pend_full_q));
  assign load       = take_input || take_pend;
  assign stash      = i_sym_valid && !take_input && (!pend_full_q || take_pend);
  assign drop       = i_sym_valid && !take_input && pend_full_q && !take_pend;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_re_d    = act_re_q;
    act_im_d    = act_im_q;
    pend_re_d   = pend_re_q;
    pend_im_d   = pend_im_q;
    pend_full_d = pend_full_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    overflow_d  = overflow_q;

    if (load) begin
      act_re_d = take_pend ? pend_re_q : i_sym_re;
      act_im_d = take_pend ? pend_im_q : i_sym_im;
      state_d  = START_STATE;
      idx_d    = START_IDX;
      valid_d  = 1'b1;
      sop_d    = 1'b1;
      eop_d    = 1'b0;
    end else if (fire) begin
      if (eop_q) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end else begin
        sop_d = 1'b0;
        if (state_q == ST_CP && idx_q == LAST_IDX) begin
          state_d = ST_BODY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        eop_d = (state_d == ST_BODY) && (idx_d == LAST_IDX);
      end
    end

    if (take_pend) begin
      pend_full_d = 1'b0;
    end
    if (stash) begin
      pend_re_d   = i_sym_re;
      pend_im_d   = i_sym_im;
      pend_full_d = 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE) || pend_full_d;
  end

  // Word view of the buffer that will be active next cycle.
  generate
    for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_unpack
      assign nxt_re_w[gi] = act_re_d[gi*WORD_SIZE +: WORD_SIZE];
      assign nxt_im_w[gi] = act_im_d[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (load || (fire && !eop_q)) begin
      re_d = nxt_re_w[idx_d[IDX_W-2:0]];
      im_d = nxt_im_w[idx_d[IDX_W-2:0]];
    end else if (fire) begin
      re_d = '0;
      im_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      act_re_q    <= '0;
      act_im_q    <= '0;
      pend_re_q   <= '0;
      pend_im_q   <= '0;
      pend_full_q <= 1'b0;
      valid_q     <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_re_q    <= act_re_d;
      act_im_q    <= act_im_d;
      pend_re_q   <= pend_re_d;
      pend_im_q   <= pend_im_d;
      pend_full_q <= pend_full_d;
      valid_q     <= valid_d;
      re_q        <= re_d;
      im_q        <= im_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_re       = re_q;
  assign o_im       = im_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_busy     = busy_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_ofdm_symbol_serializer.sv
// Scoreboard bench for ofdm_symbol_serializer: default build (CP_LEN=4) plus a CP_LEN=0 build.
module tb_ofdm_symbol_serializer;

  localparam int W   = 16;
  localparam int N   = 16;
  localparam int CP0 = 4;
  localparam int CP1 = 0;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sop;
    logic         eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic sv0 = 1'b0;
  logic sv1 = 1'b0;
  logic [N*W-1:0] sre0 = '0, sim0 = '0, sre1 = '0, sim1 = '0;

  logic         v0, sop0, eop0, busy0, ovf0;
  logic [W-1:0] re0, im0;
  logic         v1, sop1, eop1, busy1, ovf1;
  logic [W-1:0] re1, im1;

  beat_t q0[$];
  beat_t q1[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    rand_rdy = 0;
  bit    stalled[2];
  bit    gap_chk[2];
  beat_t held[2];

  ofdm_symbol_serializer #(.WORD_SIZE(W), .N_POINTS(N), .CP_LEN(CP0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_sym_valid(sv0), .i_sym_re(sre0), .i_sym_im(sim0),
    .i_ready(rdy), .o_valid(v0), .o_re(re0), .o_im(im0), .o_sop(sop0), .o_eop(eop0),
    .o_busy(busy0), .o_overflow(ovf0)
  );

  ofdm_symbol_serializer #(.WORD_SIZE(W), .N_POINTS(N), .CP_LEN(CP1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_sym_valid(sv1), .i_sym_re(sre1), .i_sym_im(sim1),
    .i_ready(rdy), .o_valid(v1), .o_re(re1), .o_im(im1), .o_sop(sop1), .o_eop(eop1),
    .o_busy(busy1), .o_overflow(ovf1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int which, input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                     input logic sop, input logic eop);
    beat_t cur;
    beat_t e;
    int    left;
    cur = {re, im, sop, eop};
    if (stalled[which]) begin
      chk($sformatf("dut%0d_stall_valid", which), 64'(v), 64'(1));
      chk($sformatf("dut%0d_stall_beat", which), 64'(cur), 64'(held[which]));
    end
    if (gap_chk[which]) begin
      chk($sformatf("dut%0d_no_gap", which), 64'(v), 64'(1));
      gap_chk[which] = 0;
    end
    if (v && rdy) begin
      left = (which == 0) ? q0.size() : q1.size();
      n_vec++;
      assert (left != 0) else begin
        n_err++;
        $error("FAIL dut%0d_extra_beat observed=%0h expected=none", which, cur);
      end
      if (left != 0) begin
        if (which == 0) e = q0.pop_front();
        else            e = q1.pop_front();
        chk($sformatf("dut%0d_re", which),  64'(re),  64'(e.re));
        chk($sformatf("dut%0d_im", which),  64'(im),  64'(e.im));
        chk($sformatf("dut%0d_sop", which), 64'(sop), 64'(e.sop));
        chk($sformatf("dut%0d_eop", which), 64'(eop), 64'(e.eop));
        if (e.eop && left > 1) gap_chk[which] = 1;
      end
    end
    stalled[which] = v && !rdy;
    held[which]    = cur;
  endtask

  task automatic step();
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    mon(0, v0, re0, im0, sop0, eop0);
    mon(1, v1, re1, im1, sop1, eop1);
    @(posedge clk);
    #1;
  endtask

  task automatic push_sym(input int which, input int re_base, input int im_base);
    int    cp;
    int    k;
    beat_t b;
    cp = (which == 0) ? CP0 : CP1;
    for (int i = 0; i < cp + N; i++) begin
      k     = (i < cp) ? (N - cp + i) : (i - cp);
      b.re  = W'(re_base + k);
      b.im  = W'(im_base - k);
      b.sop = (i == 0);
      b.eop = (i == cp + N - 1);
      if (which == 0) q0.push_back(b);
      else            q1.push_back(b);
    end
  endtask

  task automatic pulse(input int which, input int re_base, input int im_base, input bit accept);
    logic [N*W-1:0] r;
    logic [N*W-1:0] m;
    for (int k = 0; k < N; k++) begin
      r[k*W +: W] = W'(re_base + k);
      m[k*W +: W] = W'(im_base - k);
    end
    if (which == 0) begin
      sre0 = r; sim0 = m; sv0 = 1'b1;
    end else begin
      sre1 = r; sim1 = m; sv1 = 1'b1;
    end
    if (accept) push_sym(which, re_base, im_base);
    step();
    sv0 = 1'b0;
    sv1 = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_left", 64'(q0.size() + q1.size()), 64'(0));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_valid"},    64'(v0),    64'(0));
    chk({pfx, "_re"},       64'(re0),   64'(0));
    chk({pfx, "_im"},       64'(im0),   64'(0));
    chk({pfx, "_sop"},      64'(sop0),  64'(0));
    chk({pfx, "_eop"},      64'(eop0),  64'(0));
    chk({pfx, "_busy"},     64'(busy0), 64'(0));
    chk({pfx, "_overflow"}, 64'(ovf0),  64'(0));
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    chk_zero("reset");
    chk("reset_busy1", 64'(busy1), 64'(0));

    // 1: ramp symbol, always ready; first beat one cycle after the pulse
    pulse(0, 0, 0, 1);
    chk("t1_latency_valid", 64'(v0),   64'(1));
    chk("t1_first_sop",     64'(sop0), 64'(1));
    chk("t1_first_re",      64'(re0),  64'(12));
    drain();
    chk("t1_valid_after", 64'(v0),    64'(0));
    chk("t1_busy_after",  64'(busy0), 64'(0));

    // 2: same symbol under random backpressure
    rand_rdy = 1;
    pulse(0, 0, 0, 1);
    drain();
    rand_rdy = 0;
    rdy      = 1'b1;
    chk("t2_busy_after", 64'(busy0), 64'(0));

    // 3: second symbol arrives at beat 5, follows with zero gap
    pulse(0, 0, 0, 1);
    steps(5);
    pulse(0, 100, 50, 1);
    chk("t3_busy_pending", 64'(busy0), 64'(1));
    drain();
    chk("t3_overflow", 64'(ovf0),  64'(0));
    chk("t3_busy",     64'(busy0), 64'(0));

    // 4: three symbols during one: A and B streamed, C dropped
    pulse(0, 200, 0, 1);
    steps(3);
    pulse(0, 300, 1000, 1);
    chk("t4_overflow_b", 64'(ovf0), 64'(0));
    steps(2);
    pulse(0, 400, 2000, 0);
    chk("t4_overflow_c", 64'(ovf0), 64'(1));
    drain();
    chk("t4_overflow_sticky", 64'(ovf0),  64'(1));
    chk("t4_busy",            64'(busy0), 64'(0));

    // 5: reset at beat 10 with a pending symbol
    pulse(0, 500, 0, 1);
    steps(2);
    pulse(0, 600, 0, 1);
    steps(7);
    chk("t5_beat10_re", 64'(re0), 64'(W'(500 + 6)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    q0.delete();
    stalled[0] = 0;
    gap_chk[0] = 0;
    chk_zero("t5_after_rst");
    steps(3);
    chk("t5_idle_valid", 64'(v0), 64'(0));
    pulse(0, 700, 10, 1);
    chk("t5_restart_sop", 64'(sop0), 64'(1));
    drain();

    // 6: CP_LEN=0 build
    pulse(1, 0, 0, 1);
    chk("t6_first_valid", 64'(v1),   64'(1));
    chk("t6_first_sop",   64'(sop1), 64'(1));
    chk("t6_first_re",    64'(re1),  64'(0));
    drain();
    chk("t6_busy_after",  64'(busy1), 64'(0));
    chk("t6_valid_after", 64'(v1),    64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
